regfile_multiport: RTL and testbench

Parametrised register file and successor to the fixed 32×32, two-read/one-write file in the datapath. Adds a configurable read-port count, byte-strobed writes, a write-to-read bypass, an optional hardwired zero register, and a sequenced clear. A clear runs after reset or on request, so contents are always defined before use. It sits between decode, which supplies read addresses, and writeback, which supplies writes, in the CPU pipeline.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_multiport_read_port.sv | 26 ++
 rtl/regfile_multiport.sv | 77 +++++++
 tb/tb_regfile_multiport.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type, default sizes and byte-merge helper for the register file.
package regfile_pkg;
    typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;
    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH = 32;
    // Widest entry the merge helper handles; callers widen and truncate around it.
    localparam int RF_MAX_W = 256;
    function automatic logic [RF_MAX_W-1:0] byte_merge(
        input logic [RF_MAX_W-1:0] old_v,
        input logic [RF_MAX_W-1:0] new_v,
        input logic [RF_MAX_W/8-1:0] strobe
    );
        logic [RF_MAX_W-1:0] r;
        for (int b = 0; b < RF_MAX_W / 8; b++) r[b*8 +: 8] = strobe[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return r;
    endfunction
endpackage

// File: rtl/regfile_multiport_read_port.sv
// regfile_read_port: one combinational read port with range check, zero masking, bypass and ready gating.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH = RF_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              write_hit,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [DATA_W/8-1:0] write_strobe,
    output logic [DATA_W-1:0] data
);
    logic              blank;
    logic [DATA_W-1:0] merged;
    always_comb begin
        blank = !ready || ({1'b0, addr} >= (ADDR_W+1)'(DEPTH)) || (ZERO_REG != 0 && addr == '0);
        merged = DATA_W'(byte_merge(RF_MAX_W'(stored), RF_MAX_W'(write_data), (RF_MAX_W/8)'(write_strobe)));
        data = blank ? '0 : (write_hit && write_addr == addr) ? merged : stored;
    end
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised multi-read register file with byte strobes, bypass and sequenced clear.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH = RF_DEPTH,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_READ*ADDR_W-1:0] read_addr,
    output logic [NUM_READ*DATA_W-1:0] read_data,
    input  logic                       write_enable,
    input  logic [ADDR_W-1:0]          write_addr,
    input  logic [DATA_W-1:0]          write_data,
    input  logic [DATA_W/8-1:0]        write_strobe,
    input  logic                       clear_req,
    output logic                       ready
);
    rf_state_t         state, state_next;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_last, write_accept;
    logic [DATA_W-1:0] write_merged;

    always_ff @(posedge clock) begin
        if (reset) state <= RF_CLEAR;
        else state <= state_next;
    end

    always_comb begin
        clr_last = clr_ptr == ADDR_W'(DEPTH - 1);
        state_next = (state == RF_CLEAR) ? (clr_last ? RF_READY : RF_CLEAR) : (clear_req ? RF_CLEAR : RF_READY);
    end

    always_comb ready = state == RF_READY;

    // The pointer rests at 0 outside a sweep so every clear starts from entry 0.
    always_ff @(posedge clock) begin
        if (reset) clr_ptr <= '0;
        else clr_ptr <= (state == RF_CLEAR && !clr_last) ? clr_ptr + 1'b1 : '0;
    end

    always_comb begin
        write_accept = ready && !reset && !clear_req && write_enable
            && ({1'b0, write_addr} < (ADDR_W+1)'(DEPTH))
            && !(ZERO_REG != 0 && write_addr == '0);
        write_merged = DATA_W'(byte_merge(RF_MAX_W'(mem[write_addr]), RF_MAX_W'(write_data), (RF_MAX_W/8)'(write_strobe)));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == RF_CLEAR) mem[clr_ptr] <= '0;
            else if (write_accept) mem[write_addr] <= write_merged;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        regfile_read_port #(
            .DATA_W(DATA_W),
            .DEPTH(DEPTH),
            .ZERO_REG(ZERO_REG),
            .ADDR_W(ADDR_W)
        ) u_rd (
            .ready(ready),
            .addr(read_addr[i*ADDR_W +: ADDR_W]),
            .stored(mem[read_addr[i*ADDR_W +: ADDR_W]]),
            .write_hit(write_accept),
            .write_addr(write_addr),
            .write_data(write_data),
            .write_strobe(write_strobe),
            .data(read_data[i*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed checks of default, no-zero-register and 4-port/24-deep configurations.
module tb_regfile_multiport;
    logic         clock = 1'b0;
    logic         reset, write_enable, clear_req;
    logic [4:0]   write_addr;
    logic [31:0]  write_data;
    logic [3:0]   write_strobe;
    logic [9:0]   ra;
    logic [19:0]  ra4;
    logic [63:0]  rd, rd_nz;
    logic [127:0] rd4;
    logic         ready, ready_nz, ready4;
    int           compared = 0;
    int           mismatched = 0;

    always #5 clock = ~clock;

    regfile_multiport dut (
        .clock(clock), .reset(reset), .read_addr(ra), .read_data(rd),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .write_strobe(write_strobe), .clear_req(clear_req), .ready(ready)
    );
    regfile_multiport #(.ZERO_REG(0)) dut_nz (
        .clock(clock), .reset(reset), .read_addr(ra), .read_data(rd_nz),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .write_strobe(write_strobe), .clear_req(clear_req), .ready(ready_nz)
    );
    regfile_multiport #(.NUM_READ(4), .DEPTH(24)) dut4 (
        .clock(clock), .reset(reset), .read_addr(ra4), .read_data(rd4),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .write_strobe(write_strobe), .clear_req(clear_req), .ready(ready4)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        write_enable = 1'b0;
        clear_req = 1'b0;
        write_strobe = 4'h0;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        write_enable = 1'b1;
        write_addr = a;
        write_data = d;
        write_strobe = s;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle();
        write_addr = '0;
        write_data = '0;
        ra = '0;
        ra4 = '0;
        tick();
        tick();
        #4;
        compared++;
        if (ready !== 1'b0 || rd !== 64'h0 || rd4 !== 128'h0) begin
            mismatched++;
            $display("FAIL reset_state: ready=%b rd=%h rd4=%h want ready=0 all zero", ready, rd, rd4);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            tick();
            compared++;
            if (ready !== (n == 32) || ready4 !== (n >= 24)) begin
                mismatched++;
                $display("FAIL reset_ready edge %0d: ready=%b ready4=%b want %b %b", n, ready, ready4, n == 32, n >= 24);
            end
        end
    endtask

    task automatic test_reset_clears;
        write_reg(5'd9, 32'hCAFEF00D, 4'hF);
        tick();
        idle();
        ra = {5'd0, 5'd9};
        #4;
        compared++;
        if (rd[31:0] !== 32'hCAFEF00D) begin
            mismatched++;
            $display("FAIL pre_reset_write: got %h want cafef00d", rd[31:0]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #4;
        compared++;
        if (ready !== 1'b0 || rd[31:0] !== 32'h0) begin
            mismatched++;
            $display("FAIL sweep_read: ready=%b data=%h want 0 0", ready, rd[31:0]);
        end
        repeat (32) tick();
        compared++;
        if (ready !== 1'b1 || rd[31:0] !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_cleared: ready=%b data=%h want 1 0", ready, rd[31:0]);
        end
    endtask

    task automatic test_byte_strobe;
        write_reg(5'd5, 32'hDEADBEEF, 4'hF);
        ra = {5'd5, 5'd0};
        tick();
        write_reg(5'd5, 32'h000000AA, 4'b0001);
        #4;
        compared++;
        if (rd[63:32] !== 32'hDEADBEAA) begin
            mismatched++;
            $display("FAIL strobe_bypass: got %h want deadbeaa", rd[63:32]);
        end
        tick();
        idle();
        #4;
        compared++;
        if (rd[63:32] !== 32'hDEADBEAA) begin
            mismatched++;
            $display("FAIL strobe_stored: got %h want deadbeaa", rd[63:32]);
        end
        write_reg(5'd5, 32'h11111111, 4'b0000);
        tick();
        idle();
        #4;
        compared++;
        if (rd[63:32] !== 32'hDEADBEAA) begin
            mismatched++;
            $display("FAIL strobe_zero: got %h want deadbeaa", rd[63:32]);
        end
    endtask

    task automatic test_bypass;
        write_reg(5'd7, 32'hFFFFFFFF, 4'hF);
        tick();
        write_reg(5'd7, 32'h12345678, 4'b0110);
        ra = {5'd7, 5'd7};
        #4;
        compared++;
        if (rd[31:0] !== 32'hFF3456FF || rd[63:32] !== 32'hFF3456FF) begin
            mismatched++;
            $display("FAIL bypass_both: p0=%h p1=%h want ff3456ff", rd[31:0], rd[63:32]);
        end
        tick();
        idle();
        #4;
        compared++;
        if (rd[31:0] !== 32'hFF3456FF) begin
            mismatched++;
            $display("FAIL bypass_stored: got %h want ff3456ff", rd[31:0]);
        end
    endtask

    task automatic test_zero_reg;
        write_reg(5'd0, 32'hFFFFFFFF, 4'hF);
        ra = '0;
        #4;
        compared++;
        if (rd[31:0] !== 32'h0) begin
            mismatched++;
            $display("FAIL zero_same_cycle: got %h want 0", rd[31:0]);
        end
        tick();
        idle();
        #4;
        compared++;
        if (rd[31:0] !== 32'h0) begin
            mismatched++;
            $display("FAIL zero_after: got %h want 0", rd[31:0]);
        end
        compared++;
        if (rd_nz[31:0] !== 32'hFFFFFFFF) begin
            mismatched++;
            $display("FAIL nozero_reg0: got %h want ffffffff", rd_nz[31:0]);
        end
    endtask

    task automatic test_clear;
        write_reg(5'd3, 32'h00000077, 4'hF);
        tick();
        write_reg(5'd3, 32'h00000001, 4'hF);
        clear_req = 1'b1;
        ra = {5'd3, 5'd3};
        #4;
        compared++;
        if (ready !== 1'b1 || rd[31:0] !== 32'h77) begin
            mismatched++;
            $display("FAIL clear_req_cycle: ready=%b data=%h want 1 77", ready, rd[31:0]);
        end
        tick();
        idle();
        compared++;
        if (ready !== 1'b0 || rd[31:0] !== 32'h0) begin
            mismatched++;
            $display("FAIL clear_start: ready=%b data=%h want 0 0", ready, rd[31:0]);
        end
        for (int n = 1; n <= 32; n++) begin
            if (n == 5) begin
                write_reg(5'd3, 32'hFF, 4'hF);
                clear_req = 1'b1;
            end else begin
                idle();
            end
            tick();
            compared++;
            if (ready !== (n == 32)) begin
                mismatched++;
                $display("FAIL clear_ready edge %0d: got %b want %b", n, ready, n == 32);
            end
        end
        idle();
        #4;
        compared++;
        if (rd[31:0] !== 32'h0) begin
            mismatched++;
            $display("FAIL clear_dropped_write: got %h want 0", rd[31:0]);
        end
    endtask

    task automatic test_reset_mid_sweep;
        clear_req = 1'b1;
        tick();
        idle();
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            tick();
            compared++;
            if (ready !== (n == 32)) begin
                mismatched++;
                $display("FAIL mid_sweep_reset edge %0d: got %b want %b", n, ready, n == 32);
            end
        end
    endtask

    task automatic test_wide;
        write_reg(5'd1, 32'hA1A1A1A1, 4'hF);
        tick();
        write_reg(5'd2, 32'hB2B2B2B2, 4'hF);
        tick();
        write_reg(5'd20, 32'hC3C3C3C3, 4'hF);
        tick();
        write_reg(5'd23, 32'hD4D4D4D4, 4'hF);
        tick();
        write_reg(5'd30, 32'hEEEEEEEE, 4'hF);
        ra4 = {5'd30, 5'd30, 5'd30, 5'd30};
        ra = {5'd0, 5'd30};
        #4;
        compared++;
        if (rd4 !== 128'h0) begin
            mismatched++;
            $display("FAIL wide_oob_bypass: got %h want 0", rd4);
        end
        compared++;
        if (rd[31:0] !== 32'hEEEEEEEE) begin
            mismatched++;
            $display("FAIL deep_reg30_bypass: got %h want eeeeeeee", rd[31:0]);
        end
        tick();
        idle();
        ra4 = {5'd30, 5'd24, 5'd6, 5'd23};
        #4;
        compared++;
        if (rd4 !== {32'h0, 32'h0, 32'h0, 32'hD4D4D4D4}) begin
            mismatched++;
            $display("FAIL wide_boundary: got %h want 0/0/0/d4d4d4d4", rd4);
        end
        ra4 = {5'd23, 5'd20, 5'd2, 5'd1};
        #1;
        compared++;
        if (rd4 !== {32'hD4D4D4D4, 32'hC3C3C3C3, 32'hB2B2B2B2, 32'hA1A1A1A1}) begin
            mismatched++;
            $display("FAIL wide_four_ports: got %h want d4../c3../b2../a1..", rd4);
        end
        compared++;
        if (rd[31:0] !== 32'hEEEEEEEE) begin
            mismatched++;
            $display("FAIL deep_reg30_stored: got %h want eeeeeeee", rd[31:0]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_reset_clears();
        test_byte_strobe();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_reset_mid_sweep();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
